// File: rtl/data_stack.sv
// J1a data stack: a dedicated top-of-stack register plus a circular array
// holding the deeper items, with sticky wrap flags for debug.
module data_stack #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  resetq,
    input  logic                  stackEnable,
    input  logic [WIDTH-1:0]      topOfDataStackNew,
    input  logic [1:0]            stackDelta,
    input  logic                  flagClear,
    output logic [WIDTH-1:0]      topOfDataStack,
    output logic [WIDTH-1:0]      secondItemOfDataStack,
    output logic [DEPTH_LOG2-1:0] dataStackPointer,
    output logic                  stackOverflow,
    output logic                  stackUnderflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      st0_q, st0_d;
    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [WIDTH-1:0]      mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] dsp_q, dsp_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;

    logic [DEPTH_LOG2-1:0] delta_ext;
    logic [DEPTH_LOG2-1:0] dsp_inc;
    logic                  push;
    logic                  ovf_set;
    logic                  udf_set;

    // Delta is a 2-bit two's-complement value; sign-extend to pointer width.
    assign delta_ext = DEPTH_LOG2'($signed(stackDelta));
    assign dsp_inc   = dsp_q + DEPTH_LOG2'(1);
    assign push      = stackEnable && (stackDelta == 2'b01);
    assign ovf_set   = push && (dsp_q == '1);
    assign udf_set   = stackEnable &&
                       (((stackDelta == 2'b11) && (dsp_q == '0)) ||
                        ((stackDelta == 2'b10) && (dsp_q <= DEPTH_LOG2'(1))));

    always_comb begin
        st0_d = st0_q;
        dsp_d = dsp_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (stackEnable) begin
            st0_d = topOfDataStackNew;
            dsp_d = dsp_q + delta_ext;
        end
        // Only a push spills the old top into the array.
        if (push) begin
            mem_d[dsp_inc] = st0_q;
        end

        // Clear first so a same-cycle set condition wins.
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (flagClear) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (ovf_set) ovf_d = 1'b1;
        if (udf_set) udf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            st0_q <= '0;
            dsp_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            st0_q <= st0_d;
            dsp_q <= dsp_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign topOfDataStack        = st0_q;
    assign secondItemOfDataStack = mem_q[dsp_q];
    assign dataStackPointer      = dsp_q;
    assign stackOverflow         = ovf_q;
    assign stackUnderflow        = udf_q;

endmodule

// File: tb/tb_data_stack.sv
// Directed bench for data_stack: drivers push expected snapshots into a
// queue, a negedge monitor pops and compares them against the outputs.
module tb_data_stack;

    localparam int W = 38;  // {st0[16], st1[16], dsp[4], ovf, udf}

    logic        clk;
    logic        resetq;
    logic        stackEnable;
    logic [15:0] topOfDataStackNew;
    logic [1:0]  stackDelta;
    logic        flagClear;
    logic [15:0] topOfDataStack;
    logic [15:0] secondItemOfDataStack;
    logic [3:0]  dataStackPointer;
    logic        stackOverflow;
    logic        stackUnderflow;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_checks;
    int           n_fail;

    data_stack #(.WIDTH(16), .DEPTH_LOG2(4)) dut (
        .clk                   (clk),
        .resetq                (resetq),
        .stackEnable           (stackEnable),
        .topOfDataStackNew     (topOfDataStackNew),
        .stackDelta            (stackDelta),
        .flagClear             (flagClear),
        .topOfDataStack        (topOfDataStack),
        .secondItemOfDataStack (secondItemOfDataStack),
        .dataStackPointer      (dataStackPointer),
        .stackOverflow         (stackOverflow),
        .stackUnderflow        (stackUnderflow)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] pk(input logic [15:0] st0, input logic [15:0] st1,
                                        input logic [3:0] dsp, input logic ovf,
                                        input logic udf);
        return {st0, st1, dsp, ovf, udf};
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            logic [W-1:0] a;
            string        nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = pk(topOfDataStack, secondItemOfDataStack, dataStackPointer,
                    stackOverflow, stackUnderflow);
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got st0=%h st1=%h dsp=%0d ovf=%b udf=%b, want st0=%h st1=%h dsp=%0d ovf=%b udf=%b",
                         nm, a[37:22], a[21:6], a[5:2], a[1], a[0],
                         e[37:22], e[21:6], e[5:2], e[1], e[0]);
            end
        end
    end

    // Driver tasks
    task automatic expect_state(input string nm, input logic [15:0] st0, input logic [15:0] st1,
                                input logic [3:0] dsp, input logic ovf, input logic udf);
        exp_q.push_back(pk(st0, st1, dsp, ovf, udf));
        name_q.push_back(nm);
    endtask

    // Asserts reset between edges so the check proves it acts asynchronously.
    task automatic do_reset(input string nm);
        @(posedge clk);
        #2;
        resetq      = 1'b0;
        stackEnable = 1'b0;
        flagClear   = 1'b0;
        #1;
        expect_state(nm, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        resetq = 1'b1;
    endtask

    task automatic step(input string nm, input logic en, input logic [15:0] nv,
                        input logic [1:0] dl, input logic clr,
                        input logic [15:0] st0, input logic [15:0] st1,
                        input logic [3:0] dsp, input logic ovf, input logic udf);
        @(negedge clk);
        stackEnable       = en;
        topOfDataStackNew = nv;
        stackDelta        = dl;
        flagClear         = clr;
        @(posedge clk);
        #1;
        expect_state(nm, st0, st1, dsp, ovf, udf);
    endtask

    localparam logic [1:0] D0 = 2'b00, DP1 = 2'b01, DM1 = 2'b11, DM2 = 2'b10;

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        resetq            = 1'b1;
        stackEnable       = 1'b0;
        topOfDataStackNew = 16'h0000;
        stackDelta        = 2'b00;
        flagClear         = 1'b0;

        // Push/pop, delta 00, then walk the pointer to 3 without writes
        do_reset("reset_initial");
        step("push1",   1, 16'h1111, DP1, 0, 16'h1111, 16'h0000, 4'd1, 0, 0);
        step("push2",   1, 16'h2222, DP1, 0, 16'h2222, 16'h1111, 4'd2, 0, 0);
        step("push3",   1, 16'h3333, DP1, 0, 16'h3333, 16'h2222, 4'd3, 0, 0);
        step("pop1",    1, 16'h2222, DM1, 0, 16'h2222, 16'h1111, 4'd2, 0, 0);
        step("delta0a", 1, 16'hBEEF, D0,  0, 16'hBEEF, 16'h1111, 4'd2, 0, 0);
        step("delta0b", 1, 16'hCAFE, D0,  0, 16'hCAFE, 16'h1111, 4'd2, 0, 0);
        step("walk_m1", 1, 16'h0001, DM1, 0, 16'h0001, 16'h0000, 4'd1, 0, 0);
        step("walk_15", 1, 16'h0002, DM2, 0, 16'h0002, 16'h0000, 4'd15, 0, 1);
        step("walk_13", 1, 16'h0003, DM2, 0, 16'h0003, 16'h0000, 4'd13, 0, 1);
        step("walk_11", 1, 16'h0004, DM2, 0, 16'h0004, 16'h0000, 4'd11, 0, 1);
        step("walk_9",  1, 16'h0005, DM2, 0, 16'h0005, 16'h0000, 4'd9,  0, 1);
        step("walk_7",  1, 16'h0006, DM2, 0, 16'h0006, 16'h0000, 4'd7,  0, 1);
        step("walk_5",  1, 16'h0007, DM2, 0, 16'h0007, 16'h0000, 4'd5,  0, 1);
        step("mem3_kept_after_delta0", 1, 16'h0008, DM2, 0, 16'h0008, 16'h2222, 4'd3, 0, 1);

        // Reset mid-run after 3 pushes; array must come back cleared
        do_reset("reset_t2");
        step("t2_push1", 1, 16'h1111, DP1, 0, 16'h1111, 16'h0000, 4'd1, 0, 0);
        step("t2_push2", 1, 16'h2222, DP1, 0, 16'h2222, 16'h1111, 4'd2, 0, 0);
        step("t2_push3", 1, 16'h3333, DP1, 0, 16'h3333, 16'h2222, 4'd3, 0, 0);
        do_reset("reset_midrun_async");
        step("t2_walk_15", 1, 16'h0040, DM1, 0, 16'h0040, 16'h0000, 4'd15, 0, 1);
        for (int k = 0; k < 7; k++) begin
            logic [3:0] d;
            d = 4'(13 - 2 * k);
            step("t2_walk_cleared", 1, 16'(16'h0041 + k), DM2, 0,
                 16'(16'h0041 + k), 16'h0000, d, 0, 1);
        end

        // Overflow: 16 pushes of 1..16
        do_reset("reset_t3");
        for (int i = 1; i <= 16; i++) begin
            step("ovf_push", 1, 16'(i), DP1, 0, 16'(i), 16'(i - 1), 4'(i), (i == 16), 0);
        end

        // Underflow by -2 from dsp 1
        do_reset("reset_t4");
        step("udf_push",  1, 16'hAAAA, DP1, 0, 16'hAAAA, 16'h0000, 4'd1,  0, 0);
        step("udf_pop2",  1, 16'h5555, DM2, 0, 16'h5555, 16'h0000, 4'd15, 0, 1);

        // Stall with random inputs, then flag clear behaviour
        for (int s = 0; s < 5; s++) begin
            step("stall_hold", 0, 16'($urandom_range(0, 65535)), 2'($urandom_range(0, 3)), 0,
                 16'h5555, 16'h0000, 4'd15, 0, 1);
        end
        step("clear_disabled", 0, 16'h7777, DM1, 1, 16'h5555, 16'h0000, 4'd15, 0, 0);
        step("wrap_push",      1, 16'h1234, DP1, 0, 16'h1234, 16'h5555, 4'd0,  1, 0);
        step("clear_vs_set",   1, 16'h4321, DM1, 1, 16'h4321, 16'h0000, 4'd15, 0, 1);
        step("clear_only",     0, 16'h9999, DP1, 1, 16'h4321, 16'h0000, 4'd15, 0, 0);
        step("idle",           0, 16'h0000, D0,  0, 16'h4321, 16'h0000, 4'd15, 0, 0);

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
